bus_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the CPU data bus. It decodes three word registers at `BASE_ADDR`: a write-only data port, a status register and a baud divisor. It buffers written bytes in a small FIFO and serialises them 8N1 on `txd`. It sits beside the RAM on the shared bus, and its `bus_data_r` is OR-ed or muxed into the CPU read path using `bus_hit`.

---
 rtl/uart_pkg.sv | 17 +
 rtl/byte_fifo.sv | 52 +++++
 rtl/bus_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] { Idle, Start, Data, Stop } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, head visible combinationally on dout; count/flags update the cycle after push/pop.
// Backpressure: push while full is ignored (caller flags it), pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is taken from the registered count, so a same-edge pop cannot rescue a push.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-mapped 8N1 UART transmitter; DATA write at edge E pops at E+1, frame is 10*divisor clocks, back-to-back frames gapless.
// Backpressure: none on the bus (no wait states); bytes written while the FIFO is full are dropped and flag sticky overflow.
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        bus_hit,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   offset;
  logic [1:0]    reg_sel;
  logic          data_wr;
  logic          status_wr;
  logic          ovf_set;
  logic          ovf_clr;
  logic          overflow;
  logic [15:0]   divisor;
  logic [15:0]   div_eff;
  logic [31:0]   status;

  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  tx_state_t     state, state_d;
  logic [15:0]   bit_cnt, cnt_d;
  logic [2:0]    bit_idx, idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [15:0]   div_lat, div_lat_d;
  logic          txd_d;
  logic          last;
  logic          unused_bits;

  assign unused_bits = ^{bus_data_w[31:16], bus_mask_w[3:2]};

  // Unsigned wrap keeps addresses below BASE_ADDR out of the window.
  assign offset    = bus_addr - BASE_ADDR;
  assign bus_hit   = (offset < 32'd3);
  assign reg_sel   = offset[1:0];
  assign data_wr   = bus_hit && (reg_sel == REG_DATA) && bus_mask_w[0];
  assign status_wr = bus_hit && (reg_sel == REG_STATUS) && bus_mask_w[0];
  assign ovf_set   = data_wr && fifo_full;
  assign ovf_clr   = status_wr && bus_data_w[ST_OVF];
  assign div_eff   = (divisor == 16'd0) ? 16'd1 : divisor;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (data_wr),
    .pop     (pop),
    .din     (bus_data_w[7:0]),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    status                          = '0;
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = overflow;
    status[ST_BUSY]                 = (state != Idle);
    status[ST_COUNT_LSB +: 8]       = 8'(fifo_count);
  end

  always_comb begin
    bus_data_r = '0;
    if (bus_hit) begin
      case (reg_sel)
        REG_STATUS:  bus_data_r = status;
        REG_DIVISOR: bus_data_r = {16'h0000, divisor};
        default:     bus_data_r = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      divisor  <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (bus_hit && (reg_sel == REG_DIVISOR)) begin
        if (bus_mask_w[0]) divisor[7:0]  <= bus_data_w[7:0];
        if (bus_mask_w[1]) divisor[15:8] <= bus_data_w[15:8];
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign last = (bit_cnt == 16'd0);

  always_comb begin
    state_d   = state;
    cnt_d     = bit_cnt;
    idx_d     = bit_idx;
    shreg_d   = shreg;
    div_lat_d = div_lat;
    pop       = 1'b0;
    txd_d     = 1'b1;
    case (state)
      Idle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = Start;
        end
      end
      Start: begin
        if (last) begin
          state_d = Data;
          cnt_d   = div_lat - 16'd1;
          idx_d   = 3'd0;
        end else begin
          cnt_d = bit_cnt - 16'd1;
        end
      end
      Data: begin
        if (last) begin
          cnt_d = div_lat - 16'd1;
          if (bit_idx == 3'd7) state_d = Stop;
          else                 idx_d   = bit_idx + 3'd1;
        end else begin
          cnt_d = bit_cnt - 16'd1;
        end
      end
      Stop: begin
        if (last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = Start;
          end else begin
            state_d = Idle;
          end
        end else begin
          cnt_d = bit_cnt - 16'd1;
        end
      end
      default: state_d = Idle;
    endcase
    // The divisor is captured only at pop, so mid-frame DIVISOR writes wait for the next byte.
    if (pop) begin
      shreg_d   = fifo_dout;
      div_lat_d = div_eff;
      cnt_d     = div_eff - 16'd1;
    end
    case (state_d)
      Start:   txd_d = 1'b0;
      Data:    txd_d = shreg_d[idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= Idle;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div_lat <= DIV_RESET;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= cnt_d;
      bit_idx <= idx_d;
      shreg   <= shreg_d;
      div_lat <= div_lat_d;
      txd     <= txd_d;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: directed bus accesses, with a serial-line monitor that decodes
// frames on txd and compares each byte against a queue filled when the byte is written.
module tb_bus_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        bus_hit;
  logic        txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_div = 868;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  bit         m_active = 1'b0;
  int         m_cyc;
  int         m_div;
  int         m_k;
  logic [7:0] m_byte;

  bus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd868)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r),
    .bus_hit    (bus_hit),
    .txd        (txd)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Serial monitor: samples each bit mid-way, aborts any frame cut short by reset.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (txd === 1'b0) begin
        m_active = 1'b1;
        m_cyc    = 0;
        m_div    = mon_div;
        frame_starts.push_back(cyc);
      end
    end else begin
      m_cyc++;
    end
    if (m_active && (m_cyc % m_div) == (m_div / 2)) begin
      m_k = m_cyc / m_div;
      if (m_k == 0) begin
        chk("start_bit", 32'(txd), 32'h0);
      end else if (m_k <= 8) begin
        m_byte[m_k-1] = txd;
      end else begin
        chk("stop_bit", 32'(txd), 32'h1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %h, required no frame", m_byte);
        end else begin
          chk("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
        end
        m_active = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    bus_addr   = a;
    bus_data_w = d;
    bus_mask_w = m;
  endtask

  task automatic bus_idle();
    @(negedge clock);
    bus_mask_w = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clock);
    bus_addr   = a;
    bus_mask_w = 4'b0000;
    #1;
    d = bus_data_r;
    h = bus_hit;
  endtask

  task automatic wait_idle(output int idle_cyc);
    logic [31:0] s;
    logic        h;
    s = 32'h8;
    for (int n = 0; n < 2000 && s[3]; n++) bus_read(BASE + 32'd1, s, h);
    if (s[3]) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b after 2000 polls, required 0", s[3]);
    end
    idle_cyc = cyc;
  endtask

  task automatic chk_frame_len(input string name, input int idx, input int idle_cyc, input int exp_len);
    if (frame_starts.size() <= idx) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d frames, required at least %0d", name, frame_starts.size(), idx + 1);
    end else begin
      chk(name, 32'(idle_cyc - frame_starts[idx]), 32'(exp_len));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        hit;
    int          n0;
    int          idle_cyc;

    reset_n    = 1'b0;
    bus_addr   = 32'h0;
    bus_data_w = 32'h0;
    bus_mask_w = 4'h0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset state
    bus_read(BASE + 32'd1, rd, hit);
    chk("rst_status", rd, 32'h0000_0002);
    bus_read(BASE + 32'd2, rd, hit);
    chk("rst_divisor", rd, 32'd868);
    chk("rst_txd", 32'(txd), 32'h1);

    // Lane strobes and address decode
    bus_write(BASE, 32'h0000_00AA, 4'b0010);
    bus_idle();
    bus_read(BASE + 32'd1, rd, hit);
    chk("data_lane1_no_push", rd, 32'h0000_0002);
    bus_write(BASE + 32'd2, 32'hABCD_1234, 4'b0001);
    bus_idle();
    bus_read(BASE + 32'd2, rd, hit);
    chk("div_lane0_only", rd, 32'h0000_0334);
    bus_read(BASE + 32'd3, rd, hit);
    chk("unmapped_hit", 32'(hit), 32'h0);
    chk("unmapped_data", rd, 32'h0);
    bus_read(BASE - 32'd1, rd, hit);
    chk("below_base_hit", 32'(hit), 32'h0);
    bus_read(BASE, rd, hit);
    chk("data_reg_hit", 32'(hit), 32'h1);
    chk("data_reg_reads0", rd, 32'h0);

    // Single frame, D=4: 0x55 → 0,1,0,1,0,1,0,1,0,1
    bus_write(BASE + 32'd2, 32'h0000_0004, 4'b0011);
    mon_div = 4;
    n0 = frame_starts.size();
    bus_write(BASE, 32'h0000_0055, 4'b0001);
    exp_q.push_back(8'h55);
    bus_idle();
    chk("txd_high_before_pop", 32'(txd), 32'h1);
    @(posedge clock);
    #1;
    chk("txd_low_after_pop", 32'(txd), 32'h0);
    bus_read(BASE + 32'd1, rd, hit);
    chk("status_busy", rd, 32'h0000_000A);
    wait_idle(idle_cyc);
    chk_frame_len("frame_len_d4", n0, idle_cyc, 40);
    bus_read(BASE + 32'd1, rd, hit);
    chk("status_after_frame", rd, 32'h0000_0002);

    // Back-to-back frames, D=2
    bus_write(BASE + 32'd2, 32'h0000_0002, 4'b0011);
    mon_div = 2;
    n0 = frame_starts.size();
    bus_write(BASE, 32'h0000_00FF, 4'b0001);
    exp_q.push_back(8'hFF);
    bus_write(BASE, 32'h0000_0000, 4'b0001);
    exp_q.push_back(8'h00);
    bus_idle();
    wait_idle(idle_cyc);
    chk_frame_len("b2b_total_len", n0, idle_cyc, 40);
    chk_frame_len("b2b_second_start", n0, frame_starts[frame_starts.size()-1], 20);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    // Fill FIFO at D=1000: first byte pops, 8 more fill it, 10th is dropped
    bus_write(BASE + 32'd2, 32'h0000_03E8, 4'b0011);
    mon_div = 1000;
    for (int i = 0; i < 10; i++) begin
      bus_write(BASE, 32'h10 + 32'(i), 4'b0001);
      if (i < 9) exp_q.push_back(8'h10 + 8'(i));
    end
    bus_idle();
    bus_read(BASE + 32'd1, rd, hit);
    chk("status_full_ovf", rd, 32'h0000_080D);
    bus_write(BASE + 32'd1, 32'h0000_0004, 4'b0001);
    bus_idle();
    bus_read(BASE + 32'd1, rd, hit);
    chk("status_ovf_cleared", rd, 32'h0000_0809);

    // Mid-frame reset during data bit 0 of 0x10
    repeat (1500) @(negedge clock);
    chk("txd_data_bit0", 32'(txd), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("txd_async_reset", 32'(txd), 32'h1);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    bus_read(BASE + 32'd1, rd, hit);
    chk("status_after_reset", rd, 32'h0000_0002);
    bus_read(BASE + 32'd2, rd, hit);
    chk("div_after_reset", rd, 32'd868);
    n0 = frame_starts.size();
    repeat (30) @(negedge clock);
    chk("no_frame_after_reset", 32'(frame_starts.size()), 32'(n0));
    chk("txd_idle_after_reset", 32'(txd), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
